// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub
// Description : Digit-serial adder/subtractor. Processes DIGIT bits per clock,
//               LSB first, with start/busy/done handshake and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTEP = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(NSTEP + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_a_sh;
    logic [WIDTH-1:0]       r_b_sh;
    logic [WIDTH-1:0]       r_work;
    logic                   r_carry;

    logic [DIGIT:0]         w_digit;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]       w_work_next;
    logic                   w_c_out;
    logic                   w_c_msb_in;

    assign w_digit = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};
    assign w_c_out = w_digit[DIGIT];
    // Carry into the digit's top bit recovered from its sum bit and operands.
    assign w_c_msb_in  = w_digit[DIGIT-1] ^ r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1];
    assign w_cat       = {w_digit[DIGIT-1:0], r_work};
    assign w_work_next = w_cat[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_work  <= w_work_next;
                    r_a_sh  <= r_a_sh >> DIGIT;
                    r_b_sh  <= r_b_sh >> DIGIT;
                    r_carry <= w_c_out;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        sum     <= w_work_next;
                        cout    <= w_c_out;
                        ovf     <= w_c_msb_in ^ w_c_out;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_addsub
// Description : Self-checking bench for serial_addsub (DIGIT=1 and DIGIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_i [2];
    logic         sub_i   [2];
    logic         cin_i   [2];
    logic [W-1:0] a_i     [2];
    logic [W-1:0] b_i     [2];
    logic         busy_o  [2];
    logic         done_o  [2];
    logic         cout_o  [2];
    logic         ovf_o   [2];
    logic [W-1:0] sum_o   [2];

    serial_addsub #(.WIDTH(W), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst(rst), .start(start_i[0]), .sub(sub_i[0]),
        .a(a_i[0]), .b(b_i[0]), .cin(cin_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]),
        .cout(cout_o[0]), .ovf(ovf_o[0])
    );

    serial_addsub #(.WIDTH(W), .DIGIT(4)) dut_d4 (
        .clk(clk), .rst(rst), .start(start_i[1]), .sub(sub_i[1]),
        .a(a_i[1]), .b(b_i[1]), .cin(cin_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]),
        .cout(cout_o[1]), .ovf(ovf_o[1])
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {cout, ovf, sum} from plain integer maths.
    function automatic logic [9:0] ref_op(input logic [7:0] av, input logic [7:0] bv,
                                          input logic ci, input logic sb);
        int          sa;
        int          sbv;
        int          r;
        logic [8:0]  u;
        sa  = $signed(av);
        sbv = $signed(bv);
        if (!sb) begin
            u = {1'b0, av} + {1'b0, bv} + {8'b0, ci};
            r = sa + sbv + int'(ci);
        end else begin
            u = {1'b0, av} + {1'b0, ~bv} + {8'b0, ~ci};
            r = sa - sbv - int'(ci);
        end
        return {u[8], (r > 127 || r < -128), u[7:0]};
    endfunction

    // Transaction-level model: operation result known at accept, revealed after nstep edges.
    logic         m_busy [2];
    logic         m_done [2];
    logic         m_cout [2];
    logic         m_ovf  [2];
    logic [W-1:0] m_sum  [2];
    logic [9:0]   m_res  [2];
    int           m_rem  [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_cout[k] <= 1'b0;
                m_ovf[k]  <= 1'b0;
                m_sum[k]  <= '0;
                m_rem[k]  <= 0;
            end else begin
                m_done[k] <= 1'b0;
                if (!m_busy[k]) begin
                    if (start_i[k]) begin
                        m_busy[k] <= 1'b1;
                        m_rem[k]  <= (k == 0) ? 8 : 2;
                        m_res[k]  <= ref_op(a_i[k], b_i[k], cin_i[k], sub_i[k]);
                    end
                end else if (m_rem[k] == 1) begin
                    m_busy[k] <= 1'b0;
                    m_done[k] <= 1'b1;
                    {m_cout[k], m_ovf[k], m_sum[k]} <= m_res[k];
                end else begin
                    m_rem[k] <= m_rem[k] - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check((k == 0) ? "d1_outputs" : "d4_outputs",
                      {busy_o[k], done_o[k], cout_o[k], ovf_o[k], sum_o[k]},
                      {m_busy[k], m_done[k], m_cout[k], m_ovf[k], m_sum[k]});
            end
        end
    end

    task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sb, input logic [7:0] es,
                          input logic ec, input logic eo, input int el);
        int lat;
        lat = 0;
        @(negedge clk);
        a_i[k] = av; b_i[k] = bv; cin_i[k] = ci; sub_i[k] = sb; start_i[k] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            start_i[k] = 1'b0;
            a_i[k]     = 8'($urandom);
            b_i[k]     = 8'($urandom);
            cin_i[k]   = 1'($urandom);
            sub_i[k]   = 1'($urandom);
            if (done_o[k]) begin
                lat = n;
                break;
            end
        end
        check("op_latency", lat, el);
        check("op_sum", sum_o[k], es);
        check("op_cout", cout_o[k], ec);
        check("op_ovf", ovf_o[k], eo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int npulse;
        int ops;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_i[k] = 1'b0; sub_i[k] = 1'b0; cin_i[k] = 1'b0;
            a_i[k] = '0; b_i[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_d1", {busy_o[0], done_o[0], cout_o[0], ovf_o[0], sum_o[0]}, 0);
        check("reset_d4", {busy_o[1], done_o[1], cout_o[1], ovf_o[1], sum_o[1]}, 0);
        rst = 1'b0;

        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8);
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8);
        run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8);
        run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8);
        run_op(1, 8'h3C, 8'h4B, 1'b1, 1'b0, 8'h88, 1'b0, 1'b1, 2);

        // Back-to-back stream with operands scrambled every cycle.
        @(negedge clk);
        start_i[0] = 1'b1;
        last = -1;
        npulse = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            a_i[0] = 8'($urandom); b_i[0] = 8'($urandom);
            cin_i[0] = 1'($urandom); sub_i[0] = 1'($urandom);
            if (done_o[0]) begin
                if (last >= 0) check("done_period", c - last, 9);
                last = c;
                npulse++;
            end
        end
        start_i[0] = 1'b0;
        check("stream_pulses", npulse, 5);
        for (int c = 0; c < 12 && busy_o[0]; c++) @(negedge clk);
        check("stream_idle", busy_o[0], 1'b0);

        // Abort in the middle of a run.
        @(negedge clk);
        a_i[0] = 8'h12; b_i[0] = 8'h34; cin_i[0] = 1'b0; sub_i[0] = 1'b0; start_i[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_o[0], 1'b0);
        check("abort_sum", sum_o[0], 8'h00);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("abort_no_done", done_o[0], 1'b0);
        end
        run_op(0, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'h68, 1'b1, 1'b1, 8);

        // Random traffic on both instances, including held start and rare resets.
        ops = 0;
        for (int c = 0; c < 12000; c++) begin
            @(negedge clk);
            if (done_o[0]) ops++;
            for (int k = 0; k < 2; k++) begin
                start_i[k] = ($urandom_range(0, 3) != 0);
                a_i[k]     = 8'($urandom);
                b_i[k]     = 8'($urandom);
                cin_i[k]   = 1'($urandom);
                sub_i[k]   = 1'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        check("random_op_count", (ops >= 1000), 1'b1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
